tmds_decoder_chan: RTL and testbench



---
 rtl/tmds_pkg.sv | 36 +++
 rtl/tmds_decoder_chan_align.sv | 127 ++++++++++++
 rtl/tmds_decoder_chan.sv | 89 ++++++++
 tb/tb_tmds_decoder_chan.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions for the encoder and decoder sides: control-token
// words, the word-alignment FSM states and the 10-bit TMDS word type.
package tmds_pkg;

  typedef logic [9:0] tmds_word_t;

  // Control tokens, indexed by {c1,c0}
  localparam tmds_word_t TOK_CTRL_00 = 10'h354;
  localparam tmds_word_t TOK_CTRL_01 = 10'h0AB;
  localparam tmds_word_t TOK_CTRL_10 = 10'h154;
  localparam tmds_word_t TOK_CTRL_11 = 10'h2AB;

  typedef enum logic [1:0] {
    ST_SEARCH    = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } align_state_t;

  function automatic logic is_ctrl_token(input tmds_word_t w);
    return (w == TOK_CTRL_00) || (w == TOK_CTRL_01) ||
           (w == TOK_CTRL_10) || (w == TOK_CTRL_11);
  endfunction

  // {c1,c0} carried by a control token; only meaningful when is_ctrl_token()
  function automatic logic [1:0] ctrl_bits(input tmds_word_t w);
    logic [1:0] c;
    case (w)
      TOK_CTRL_01: c = 2'b01;
      TOK_CTRL_10: c = 2'b10;
      TOK_CTRL_11: c = 2'b11;
      default:     c = 2'b00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tmds_decoder_chan_align.sv
// Word-boundary hunter for one TMDS channel: counts consecutive control
// tokens, times a search/lock window and requests bitslips from the
// deserializer. Optional lock-loss counter enabled by TMDS_ERR_CNT_EN.
module tmds_word_align
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN  = 8,
  parameter int WINDOW    = 4096,
  parameter int SLIP_WAIT = 16
) (
  input  logic        pixel_clk,
  input  logic        sys_rst_n,
  input  logic        ctrl_p0,
  output logic        bitslip,
  output logic        aligned,
  output logic [15:0] err_cnt
);

  localparam int RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int WIN_W  = $clog2(WINDOW);
  localparam int SLIP_W = $clog2(SLIP_WAIT + 1);

  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(CTRL_RUN);
  localparam logic [RUN_W-1:0]  RUN_PRE   = RUN_W'(CTRL_RUN - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(SLIP_WAIT - 1);

  align_state_t      state, state_nx;
  logic [RUN_W-1:0]  run_cnt;
  logic              run_hit_p1;
  logic [WIN_W-1:0]  win_cnt, win_nx;
  logic [SLIP_W-1:0] slip_cnt, slip_nx;
  logic              bitslip_nx;
  logic              win_exp;

  // Run counter: consecutive tokens, saturating; run hit flags the first arrival at the limit
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      run_cnt    <= '0;
      run_hit_p1 <= 1'b0;
    end else if (state == ST_SLIP_WAIT || !ctrl_p0) begin
      run_cnt    <= '0;
      run_hit_p1 <= 1'b0;
    end else if (run_cnt != RUN_MAX) begin
      run_cnt    <= run_cnt + 1'b1;
      run_hit_p1 <= (run_cnt == RUN_PRE);
    end else begin
      run_hit_p1 <= 1'b0;
    end
  end

  assign win_exp = (win_cnt == WIN_LAST);

  // Next-state logic; a run hit always takes priority over window expiry
  always_comb begin
    state_nx   = state;
    win_nx     = win_cnt + 1'b1;
    slip_nx    = '0;
    bitslip_nx = 1'b0;
    case (state)
      ST_SEARCH: begin
        if (run_hit_p1) begin
          state_nx = ST_LOCKED;
          win_nx   = '0;
        end else if (win_exp) begin
          state_nx   = ST_SLIP_WAIT;
          bitslip_nx = 1'b1;
          win_nx     = '0;
        end
      end
      ST_SLIP_WAIT: begin
        win_nx = '0;
        if (slip_cnt == SLIP_LAST) begin
          state_nx = ST_SEARCH;
        end else begin
          slip_nx = slip_cnt + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (run_hit_p1) begin
          win_nx = '0;
        end else if (win_exp) begin
          state_nx = ST_SEARCH;
          win_nx   = '0;
        end
      end
      default: begin
        state_nx = ST_SEARCH;
        win_nx   = '0;
      end
    endcase
  end

  // State, counters and registered bitslip/aligned outputs
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= ST_SEARCH;
      win_cnt  <= '0;
      slip_cnt <= '0;
      bitslip  <= 1'b0;
      aligned  <= 1'b0;
    end else begin
      state    <= state_nx;
      win_cnt  <= win_nx;
      slip_cnt <= slip_nx;
      bitslip  <= bitslip_nx;
      aligned  <= (state_nx == ST_LOCKED);
    end
  end

`ifdef TMDS_ERR_CNT_EN
  logic lock_lost;
  assign lock_lost = (state == ST_LOCKED) && (state_nx == ST_SEARCH);

  // Saturating count of lock losses, cleared only by reset
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      err_cnt <= '0;
    end else if (lock_lost && err_cnt != 16'hFFFF) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: rtl/tmds_decoder_chan.sv
// One TMDS receive channel: registers the deserialized word, classifies it
// as control token or data, decodes it and hunts for the word boundary.
// Optional lock-loss counter on err_cnt enabled by TMDS_ERR_CNT_EN.
module tmds_decoder_chan
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN  = 8,
  parameter int WINDOW    = 4096,
  parameter int SLIP_WAIT = 16
) (
  input  logic        pixel_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  tmds_word,
  output logic [7:0]  dout,
  output logic        c0,
  output logic        c1,
  output logic        de,
  output logic        bitslip,
  output logic        aligned,
  output logic [15:0] err_cnt
);

  tmds_word_t word_p0;
  logic       vld_p0;
  logic       ctrl_p0;
  logic       de_p1;

  // Undo transition minimisation: optional inversion, then XOR/XNOR chain
  function automatic logic [7:0] tmds_decode(input tmds_word_t w);
    logic [7:0] q;
    logic [7:0] d;
    q    = w[9] ? ~w[7:0] : w[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

  // ---- Stage 1: capture deserializer word ----
  // Word register carries no reset; vld_p0 gates its use after reset
  always_ff @(posedge pixel_clk) begin
    word_p0 <= tmds_word;
  end

  // Marks stage 1 as holding a real word once reset is released
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) vld_p0 <= 1'b0;
    else            vld_p0 <= 1'b1;
  end

  assign ctrl_p0 = vld_p0 && is_ctrl_token(word_p0);

  // ---- Stage 2: classify and decode ----
  // Tokens update c1/c0 and hold dout; data updates dout and holds c1/c0
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dout  <= '0;
      c0    <= 1'b0;
      c1    <= 1'b0;
      de_p1 <= 1'b0;
    end else if (vld_p0) begin
      if (ctrl_p0) begin
        {c1, c0} <= ctrl_bits(word_p0);
        de_p1    <= 1'b0;
      end else begin
        dout  <= tmds_decode(word_p0);
        de_p1 <= aligned;
      end
    end
  end

  // Gate with the live lock flag so de drops on the same edge as aligned
  assign de = de_p1 & aligned;

  tmds_word_align #(
    .CTRL_RUN  (CTRL_RUN),
    .WINDOW    (WINDOW),
    .SLIP_WAIT (SLIP_WAIT)
  ) u_align (
    .pixel_clk (pixel_clk),
    .sys_rst_n (sys_rst_n),
    .ctrl_p0   (ctrl_p0),
    .bitslip   (bitslip),
    .aligned   (aligned),
    .err_cnt   (err_cnt)
  );

endmodule

// File: tb/tb_tmds_decoder_chan.sv
// Self-checking bench for tmds_decoder_chan: vector table, randomized
// stream against a reference model, and timed alignment sequences.
module tb_tmds_decoder_chan;

  logic        pixel_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [9:0]  tmds_word = 10'h000;
  logic [7:0]  dout;
  logic        c0, c1, de, bitslip, aligned;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 pixel_clk = ~pixel_clk;

  tmds_decoder_chan dut (
    .pixel_clk (pixel_clk),
    .sys_rst_n (sys_rst_n),
    .tmds_word (tmds_word),
    .dout      (dout),
    .c0        (c0),
    .c1        (c1),
    .de        (de),
    .bitslip   (bitslip),
    .aligned   (aligned),
    .err_cnt   (err_cnt)
  );

  typedef struct {
    logic [9:0] w;
    logic [7:0] dout;
    logic [1:0] c;
    logic       de;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Token index == {c1,c0}; -1 for data words
  function automatic int tok_index(input logic [9:0] w);
    case (w)
      10'h354: return 0;
      10'h0AB: return 1;
      10'h154: return 2;
      10'h2AB: return 3;
      default: return -1;
    endcase
  endfunction

  // Reference decode: bit i of (q ^ q<<1) is q[i]^q[i-1], bit 0 is q[0]
  function automatic logic [7:0] ref_decode(input logic [9:0] w);
    logic [7:0] q;
    logic [7:0] d;
    q = w[7:0];
    if (w[9]) q = 8'hFF - q;
    d = q ^ (q << 1);
    if (!w[8]) d = d ^ 8'hFE;
    return d;
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    w = 10'($urandom);
    while (tok_index(w) >= 0) w = 10'($urandom);
    return w;
  endfunction

  // Word seen by a deserializer whose boundary sits ofs bits into a repeated token
  function automatic logic [9:0] stream_word(input logic [9:0] t, input int ofs);
    logic [9:0] w;
    for (int j = 0; j < 10; j++) w[j] = t[(ofs + j) % 10];
    return w;
  endfunction

  task automatic do_reset();
    @(negedge pixel_clk);
    sys_rst_n = 1'b0;
    repeat (3) @(negedge pixel_clk);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tab [10];
    logic [9:0] pend [$];
    logic [9:0] w;
    logic [7:0] m_dout;
    logic [1:0] m_c;
    logic       m_de;
    logic       prev_bs;
    logic [9:0] tok;
    int         idx, ofs, n_slip, last_slip;
    logic [15:0] exp_err;

`ifdef TMDS_ERR_CNT_EN
    exp_err = 16'd1;
`else
    exp_err = 16'd0;
`endif

    tab[0] = '{10'h2FF, 8'hFE, 2'b00, 1'b1};
    tab[1] = '{10'h100, 8'h00, 2'b00, 1'b1};
    tab[2] = '{10'h0AB, 8'h00, 2'b01, 1'b0};
    tab[3] = '{10'h055, 8'h01, 2'b01, 1'b1};
    tab[4] = '{10'h154, 8'h01, 2'b10, 1'b0};
    tab[5] = '{10'h1AA, 8'hFE, 2'b10, 1'b1};
    tab[6] = '{10'h2AB, 8'hFE, 2'b11, 1'b0};
    tab[7] = '{10'h200, 8'hFF, 2'b11, 1'b1};
    tab[8] = '{10'h354, 8'hFF, 2'b00, 1'b0};
    tab[9] = '{10'h10F, 8'h11, 2'b00, 1'b1};

    // Reset held: random words, everything stays zero
    sys_rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tmds_word = 10'($urandom);
      @(negedge pixel_clk);
      check("reset_outputs", {3'b0, dout, c1, c0, de, bitslip, aligned, err_cnt}, 32'h0);
    end
    sys_rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tmds_word = rand_data();
      @(negedge pixel_clk);
      check("post_reset_de", de, 0);
      check("post_reset_aligned", aligned, 0);
    end

    // Lock on 20 x 0x354; 8th token sampled on edge 8, aligned after edge 10
    for (int e = 1; e <= 20; e++) begin
      tmds_word = 10'h354;
      @(posedge pixel_clk);
      @(negedge pixel_clk);
      check("lock_de", de, 0);
      check("lock_c", {c1, c0}, 0);
      if (e == 9)  check("lock_aligned_e9", aligned, 0);
      if (e == 10) check("lock_aligned_e10", aligned, 1);
    end

    // Vector table while locked
    for (int i = 0; i < 10; i++) begin
      tmds_word = tab[i].w;
      @(posedge pixel_clk);
      @(posedge pixel_clk);
      @(negedge pixel_clk);
      check("tab_dout", dout, tab[i].dout);
      check("tab_c", {c1, c0}, tab[i].c);
      check("tab_de", de, tab[i].de);
    end

    // Randomized stream against the reference model (still locked)
    m_dout = 8'h11;
    m_c    = 2'b00;
    for (int i = 0; i < 600; i++) begin
      if (pend.size() == 2) begin
        w   = pend.pop_front();
        idx = tok_index(w);
        if (idx >= 0) begin
          m_c  = idx[1:0];
          m_de = 1'b0;
        end else begin
          m_dout = ref_decode(w);
          m_de   = 1'b1;
        end
        check("rand_dout", dout, m_dout);
        check("rand_c", {c1, c0}, m_c);
        check("rand_de", de, m_de);
        check("rand_aligned", aligned, 1);
      end
      if ($urandom_range(0, 9) < 3) begin
        case ($urandom_range(0, 3))
          0: w = 10'h354;
          1: w = 10'h0AB;
          2: w = 10'h154;
          default: w = 10'h2AB;
        endcase
      end else begin
        w = rand_data();
      end
      tmds_word = w;
      pend.push_back(w);
      @(negedge pixel_clk);
    end

    // Lock loss: data only for a full window
    for (int i = 0; i < 4096; i++) begin
      tmds_word = rand_data();
      @(negedge pixel_clk);
      if (!aligned) check("loss_de_forced", de, 0);
    end
    check("loss_aligned", aligned, 0);
    check("loss_de", de, 0);
    check("loss_err_cnt", err_cnt, exp_err);

    // Slip hunt: token stream rotated by 3 bits
    do_reset();
    tok       = 10'h354;
    ofs       = 3;
    n_slip    = 0;
    last_slip = 0;
    prev_bs   = 1'b0;
    for (int e = 1; e <= 20000; e++) begin
      tmds_word = stream_word(tok, ofs);
      @(posedge pixel_clk);
      @(negedge pixel_clk);
      if (!aligned) check("slip_de_forced", de, 0);
      if (bitslip) begin
        check("slip_width", prev_bs, 0);
        n_slip++;
        if (n_slip == 1) check("slip_first_edge", e, 4096);
        else             check("slip_gap_ok", (e - last_slip) >= 4112, 1);
        last_slip = e;
        ofs = (ofs + 9) % 10;
      end
      prev_bs = bitslip;
      if (aligned) break;
    end
    check("slip_locked", aligned, 1);
    check("slip_count", n_slip, 3);

    // Reset aborts an in-flight bitslip immediately
    do_reset();
    for (int e = 1; e <= 4096; e++) begin
      tmds_word = rand_data();
      @(posedge pixel_clk);
      @(negedge pixel_clk);
      if (e == 4095) check("abort_pre_bitslip", bitslip, 0);
      if (e == 4096) check("abort_bitslip_set", bitslip, 1);
    end
    #1 sys_rst_n = 1'b0;
    #1 check("abort_bitslip_cleared", bitslip, 0);
    check("abort_aligned", aligned, 0);

    // Tie: 8th 0x0AB sampled on edge 4094 so the run hit meets window expiry
    do_reset();
    for (int e = 1; e <= 4100; e++) begin
      if (e >= 4087 && e <= 4094) tmds_word = 10'h0AB;
      else                        tmds_word = rand_data();
      @(posedge pixel_clk);
      @(negedge pixel_clk);
      check("tie_bitslip", bitslip, 0);
      if (e == 4095) check("tie_aligned_e4095", aligned, 0);
      if (e == 4096) begin
        check("tie_aligned_e4096", aligned, 1);
        check("tie_c", {c1, c0}, 2'b01);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
